// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one req/ack data-bus transaction per access, with lane steering and load extension.
// Optional MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of forcing them aligned.
module mem_access_unit #(
    parameter int B        = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [B-1:0] addr,
    input  logic [B-1:0] store_data,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_size,
    input  logic         mem_unsigned,
    output logic         stall,
    output logic         mem_req,
    output logic         mem_we,
    output logic [B-1:0] mem_addr,
    output logic [3:0]   mem_be,
    output logic [B-1:0] mem_wdata,
    input  logic [B-1:0] mem_rdata,
    input  logic         mem_ack,
    output logic [B-1:0] load_data,
    output logic         load_valid,
    output logic         bus_err,
    output logic         misalign
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);

    state_t       state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         req_q, req_d, we_q, we_d;
    logic [B-1:0] addr_q, addr_d, wdata_q, wdata_d, ld_q, ld_d;
    logic [3:0]   be_q, be_d;
    logic [1:0]   a_q, a_d, size_q, size_d;
    logic         uns_q, uns_d, lv_q, lv_d, berr_q, berr_d, mis_q, mis_d;

    logic         access, trap, stall_c;
    logic [1:0]   a_eff;
    logic [3:0]   be_new;
    logic [B-1:0] wdata_new, ext;
    logic [7:0]   byte_v;
    logic [15:0]  half_v;

    assign access = in_valid & (mem_read | mem_write);

`ifdef MISALIGN_TRAP_EN
    assign trap = access & (((mem_size == 2'b01) & addr[0]) | (mem_size[1] & (|addr[1:0])));
`else
    assign trap = 1'b0;
`endif

    // Without the trap, half/word offsets are forced aligned here.
    always_comb begin
        unique case (mem_size)
            2'b00: begin
                a_eff     = addr[1:0];
                be_new    = 4'b0001 << addr[1:0];
                wdata_new = {4{store_data[7:0]}};
            end
            2'b01: begin
                a_eff     = {addr[1], 1'b0};
                be_new    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{store_data[15:0]}};
            end
            default: begin
                a_eff     = 2'b00;
                be_new    = 4'b1111;
                wdata_new = store_data;
            end
        endcase
    end

    always_comb begin
        unique case (a_q)
            2'd1:    byte_v = mem_rdata[15:8];
            2'd2:    byte_v = mem_rdata[23:16];
            2'd3:    byte_v = mem_rdata[31:24];
            default: byte_v = mem_rdata[7:0];
        endcase
        half_v = a_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (size_q)
            2'b00:   ext = {{24{byte_v[7] & ~uns_q}}, byte_v};
            2'b01:   ext = {{16{half_v[15] & ~uns_q}}, half_v};
            default: ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        a_d     = a_q;
        size_d  = size_q;
        uns_d   = uns_q;
        ld_d    = ld_q;
        lv_d    = 1'b0;
        berr_d  = 1'b0;
        mis_d   = 1'b0;
        stall_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_d = 1'b0;
                we_d  = 1'b0;
                if (trap) begin
                    mis_d = 1'b1;
                end else if (access) begin
                    stall_c = 1'b1;
                    state_d = BUSY;
                    req_d   = 1'b1;
                    we_d    = mem_write;
                    addr_d  = {addr[B-1:2], 2'b00};
                    be_d    = be_new;
                    wdata_d = wdata_new;
                    a_d     = a_eff;
                    size_d  = mem_size;
                    uns_d   = mem_unsigned;
                    cnt_d   = 8'd0;
                end
            end
            BUSY: begin
                // Ack beats a coincident timeout.
                if (mem_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    if (!we_q) begin
                        ld_d = ext;
                        lv_d = 1'b1;
                    end
                end else if (cnt_q == LAST) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    berr_d  = 1'b1;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            a_q     <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            ld_q    <= '0;
            lv_q    <= 1'b0;
            berr_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            a_q     <= a_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            ld_q    <= ld_d;
            lv_q    <= lv_d;
            berr_q  <= berr_d;
            mis_q   <= mis_d;
        end
    end

    assign stall      = stall_c & ~reset;
    assign mem_req    = req_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_be     = be_q;
    assign mem_wdata  = wdata_q;
    assign load_data  = ld_q;
    assign load_valid = lv_q;
    assign bus_err    = berr_q;
    assign misalign   = mis_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level reference model, per-cycle compare, directed + random traffic.
module tb_mem_access_unit;
    localparam int B  = 32;
    localparam int MW = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, mem_read, mem_write, mem_unsigned, mem_ack;
    logic [1:0]  mem_size;
    logic [31:0] addr, store_data, mem_rdata;
    logic        stall, mem_req, mem_we, load_valid, bus_err, misalign;
    logic [31:0] mem_addr, mem_wdata, load_data;
    logic [3:0]  mem_be;

    always #5 clk = ~clk;

    mem_access_unit #(.B(B), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .addr(addr),
        .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .load_data(load_data), .load_valid(load_valid), .bus_err(bus_err),
        .misalign(misalign)
    );

    int total = 0;
    int bad   = 0;

    logic        chk_en = 1'b0, pinned = 1'b0;
    logic        exp_stall = 1'b0, exp_req = 1'b0, exp_we = 1'b0;
    logic        exp_lv = 1'b0, exp_berr = 1'b0, exp_mis = 1'b0;
    logic [31:0] exp_addr = '0, exp_wdata = '0, exp_ld = '0;
    logic [3:0]  exp_be = '0;
    logic        pend_lv = 1'b0, pend_berr = 1'b0, pend_mis = 1'b0;
    logic [31:0] pend_ld = '0;
    logic        lit_en = 1'b0;
    logic [31:0] lit_ld = '0;

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic int m_ea(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b00) return int'(a % 4);
        if (sz == 2'b01) return (a % 4 >= 2) ? 2 : 0;
        return 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b00) return 4'(1 << m_ea(sz, a));
        if (sz == 2'b01) return 4'(3 << m_ea(sz, a));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] sd);
        if (sz == 2'b00) return (sd % 256) * 32'h01010101;
        if (sz == 2'b01) return (sd % 65536) * 32'h00010001;
        return sd;
    endfunction

    function automatic logic [31:0] m_ld(input logic [1:0] sz, input logic uns,
                                         input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * m_ea(sz, a));
        if (sz == 2'b00) begin
            v = v % 256;
            if (!uns && v >= 32'h80) v = v - 32'h100;
        end else if (sz == 2'b01) begin
            v = v % 65536;
            if (!uns && v >= 32'h8000) v = v - 32'h10000;
        end
        return v;
    endfunction

    function automatic logic m_trap(input logic [1:0] sz, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
        return (sz == 2'b01 && (a % 2) != 0) || (sz >= 2'b10 && (a % 4) != 0);
`else
        return (sz == 2'b11) && (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    // ---------------- comparison helpers ----------------
    function automatic void chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            if (!pinned) begin
                chk32("pin_be_byte3", {28'h0, m_be(2'b00, 32'h203)}, 32'h8);
                chk32("pin_lb",  m_ld(2'b00, 1'b0, 32'h203, 32'h80112233), 32'hFFFFFF80);
                chk32("pin_lbu", m_ld(2'b00, 1'b1, 32'h203, 32'h80112233), 32'h00000080);
                chk32("pin_wd_half", m_wdata(2'b01, 32'h0000ABCD), 32'hABCDABCD);
                chk32("pin_be_half", {28'h0, m_be(2'b01, 32'h302)}, 32'hC);
                chk32("pin_lh",  m_ld(2'b01, 1'b0, 32'h302, 32'h80001234), 32'hFFFF8000);
                chk32("pin_be_word_mis", {28'h0, m_be(2'b10, 32'h101)}, 32'hF);
                pinned <= 1'b1;
            end
            chk1("stall", stall, exp_stall);
            chk1("mem_req", mem_req, exp_req);
            if (exp_req) begin
                chk1("mem_we", mem_we, exp_we);
                chk32("mem_addr", mem_addr, exp_addr);
                chk32("mem_be", {28'h0, mem_be}, {28'h0, exp_be});
                chk32("mem_wdata", mem_wdata, exp_wdata);
            end
            chk1("load_valid", load_valid, exp_lv);
            if (exp_lv) chk32("load_data", load_data, exp_ld);
            if (exp_lv && lit_en) chk32("lit_load_data", load_data, lit_ld);
            chk1("bus_err", bus_err, exp_berr);
            chk1("misalign", misalign, exp_mis);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        exp_lv    = pend_lv;
        exp_ld    = pend_ld;
        exp_berr  = pend_berr;
        exp_mis   = pend_mis;
        pend_lv   = 1'b0;
        pend_berr = 1'b0;
        pend_mis  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid  = 1'($urandom);
            mem_read  = 1'b0;
            mem_write = 1'b0;
            if (!in_valid) begin
                mem_read  = 1'($urandom);
                mem_write = 1'($urandom);
            end
            addr      = $urandom;
            mem_size  = 2'($urandom);
            mem_ack   = 1'($urandom);
            mem_rdata = $urandom;
            exp_stall = 1'b0;
            exp_req   = 1'b0;
            tick();
        end
        mem_ack = 1'b0;
    endtask

    // d = BUSY cycle index (0-based) in which ack is given; d >= MW never acks.
    task automatic xact(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdata,
                        input int d);
        logic ack_now, to_now;
        in_valid = 1'b1; mem_read = rd; mem_write = wr; mem_size = sz;
        mem_unsigned = uns; addr = a; store_data = sd; mem_ack = 1'b0; mem_rdata = $urandom;
        exp_req = 1'b0;
        if (m_trap(sz, a)) begin
            exp_stall = 1'b0;
            pend_mis  = 1'b1;
            tick();
        end else begin
            exp_stall = 1'b1;
            tick();
            exp_req   = 1'b1;
            exp_we    = wr;
            exp_addr  = a - (a % 4);
            exp_be    = m_be(sz, a);
            exp_wdata = m_wdata(sz, sd);
            for (int k = 0; k < MW + 4; k++) begin
                ack_now   = (k == d);
                to_now    = (k == MW - 1);
                mem_ack   = ack_now;
                mem_rdata = ack_now ? rdata : $urandom;
                exp_stall = !(ack_now || to_now);
                if (ack_now && !wr) begin
                    pend_lv = 1'b1;
                    pend_ld = m_ld(sz, uns, a, rdata);
                end else if (!ack_now && to_now) begin
                    pend_berr = 1'b1;
                end
                tick();
                if (ack_now || to_now) break;
            end
        end
        in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_ack = 1'b0;
        exp_req = 1'b0; exp_stall = 1'b0;
    endtask

    initial begin
        int op, d;
        reset = 1'b1; in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        mem_size = 2'b00; mem_unsigned = 1'b0; addr = '0; store_data = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        idle(2);

        // LW, ack after 3 wait cycles
        lit_en = 1'b1; lit_ld = 32'hDEADBEEF;
        xact(1'b1, 1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 32'hDEADBEEF, 3);
        idle(1);
        // LB / LBU at byte 3
        lit_ld = 32'hFFFFFF80;
        xact(1'b1, 1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 32'h80112233, 1);
        idle(1);
        lit_ld = 32'h00000080;
        xact(1'b1, 1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 32'h80112233, 0);
        idle(1);
        lit_en = 1'b0;
        // SH upper half
        xact(1'b0, 1'b1, 2'b01, 1'b0, 32'h302, 32'h0000ABCD, 32'h0, 2);
        idle(1);
        // timeout, then ack exactly on the last allowed cycle
        xact(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h11111111, 100);
        idle(1);
        xact(1'b1, 1'b0, 2'b10, 1'b0, 32'h404, 32'h0, 32'h22222222, MW - 1);
        idle(1);

        // async reset mid-BUSY, then a stray ack
        in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'b10;
        addr = 32'h500; mem_ack = 1'b0;
        exp_stall = 1'b1; exp_req = 1'b0; tick();
        exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h500; exp_be = 4'hF;
        exp_wdata = 32'h0; store_data = 32'h0;
        tick();
        tick();
        reset = 1'b1; exp_req = 1'b0; exp_stall = 1'b0;
        tick();
        in_valid = 1'b0; mem_read = 1'b0;
        tick();
        reset = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ack = 1'b0;
        tick();
        // fresh timeout after reset takes the full wait budget
        xact(1'b1, 1'b0, 2'b00, 1'b0, 32'h601, 32'h0, 32'h0, 100);
        idle(1);

        // LW misaligned
        xact(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h12345678, 0);
        idle(1);

        repeat (300) begin
            op = $urandom_range(0, 2);
            d  = ($urandom_range(0, 9) == 0) ? $urandom_range(MW - 3, MW + 5) : $urandom_range(0, 4);
            xact(op != 1, op != 0, 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom, d);
            idle($urandom_range(0, 2));
        end
        idle(2);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
